// File: rtl/onehot_enc_pkg.sv
// Shared types and helpers for the one-hot stream encoder.
package onehot_enc_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  // All-ones value of a w-bit counter, used as its saturation point.
  function automatic logic [31:0] err_sat_max(input int w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/onehot_to_index.sv
// Combinational one-hot to binary index encoder; non-one-hot words are flagged
// and encode to their lowest set bit (zero when no bit is set).
module onehot_to_index #(
  parameter int N_IN  = 4,
  parameter int W_OUT = $clog2(N_IN)
) (
  input  logic [N_IN-1:0]  onehot_i,
  output logic [W_OUT-1:0] code_o,
  output logic             err_o
);

  // Scanning downward lets the lowest set bit win.
  always_comb begin
    code_o = '0;
    for (int i = N_IN - 1; i >= 0; i--) begin
      if (onehot_i[i]) code_o = W_OUT'(i);
    end
  end

  assign err_o = (onehot_i == '0) || ((onehot_i & (onehot_i - N_IN'(1))) != '0);

endmodule

// File: rtl/onehot_stream_encoder.sv
// Valid/ready one-hot encoder with a 1-cycle registered output stage and a
// 2-entry skid buffer so the upstream ready is a flop; counts flagged words.
module onehot_stream_encoder
  import onehot_enc_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int W_OUT = $clog2(N_IN),
  parameter int ERR_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [N_IN-1:0]  in_onehot_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [W_OUT-1:0] out_code_o,
  output logic             out_err_o,
  input  logic             clr_err_i,
  output logic [ERR_W-1:0] err_count_o
);

  localparam logic [ERR_W-1:0] ERR_SAT = ERR_W'(err_sat_max(ERR_W));

  skid_state_t      state_q;
  logic [W_OUT-1:0] main_code_q, skid_code_q;
  logic             main_err_q, skid_err_q;
  logic             in_ready_q;
  logic [ERR_W-1:0] err_count_q;

  logic [W_OUT-1:0] enc_code;
  logic             enc_err;
  logic             accept, emit;

  onehot_to_index #(
    .N_IN  (N_IN),
    .W_OUT (W_OUT)
  ) u_enc (
    .onehot_i (in_onehot_i),
    .code_o   (enc_code),
    .err_o    (enc_err)
  );

  assign accept = in_valid_i && in_ready_q;
  assign emit   = (state_q != EMPTY) && out_ready_i;

  // in_ready_q tracks next_state != FULL, so it only falls on the fill edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= EMPTY;
      main_code_q <= '0;
      main_err_q  <= 1'b0;
      skid_code_q <= '0;
      skid_err_q  <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_code_q <= enc_code;
            main_err_q  <= enc_err;
            state_q     <= ONE;
          end
        end
        ONE: begin
          if (accept && !emit) begin
            skid_code_q <= enc_code;
            skid_err_q  <= enc_err;
            state_q     <= FULL;
            in_ready_q  <= 1'b0;
          end else if (!accept && emit) begin
            state_q     <= EMPTY;
          end else if (accept && emit) begin
            main_code_q <= enc_code;
            main_err_q  <= enc_err;
          end
        end
        FULL: begin
          if (emit) begin
            main_code_q <= skid_code_q;
            main_err_q  <= skid_err_q;
            state_q     <= ONE;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q    <= EMPTY;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Clear wins over a simultaneous flagged accept.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_count_q <= '0;
    end else if (clr_err_i) begin
      err_count_q <= '0;
    end else if (accept && enc_err && (err_count_q != ERR_SAT)) begin
      err_count_q <= err_count_q + ERR_W'(1);
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = (state_q != EMPTY);
  assign out_code_o  = main_code_q;
  assign out_err_o   = main_err_q;
  assign err_count_o = err_count_q;

endmodule
